// File: rtl/mandel_point_engine.sv
// Escape-time engine: iterates z <- z^2 + c for one tagged pixel and reports the iteration count.
// Optional JULIA_MODE_EN adds julia/jc_re/jc_im: z0 = pixel point, c = (jc_re, jc_im).
module mandel_point_engine #(
  parameter  int INT_W   = 4,
  parameter  int FRAC_W  = 28,
  parameter  int COORD_W = 12,
  parameter  int ITER_W  = 16,
  localparam int W       = INT_W + FRAC_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COORD_W-1:0]  in_x,
  input  logic [COORD_W-1:0]  in_y,
  input  logic signed [W-1:0] re_start,
  input  logic signed [W-1:0] im_start,
  input  logic signed [W-1:0] re_scale,
  input  logic signed [W-1:0] im_scale,
  input  logic [ITER_W-1:0]   max_iter,
`ifdef JULIA_MODE_EN
  input  logic                julia,
  input  logic signed [W-1:0] jc_re,
  input  logic signed [W-1:0] jc_im,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [COORD_W-1:0]  out_x,
  output logic [COORD_W-1:0]  out_y,
  output logic [ITER_W-1:0]   out_iter,
  output logic                out_escaped
);
  localparam int PW = W + COORD_W + 1;
  localparam int SW = PW + 1;
  localparam int DW = 2 * W + 1;
  localparam logic signed [DW-1:0] FOUR = {{(DW-2*FRAC_W-3){1'b0}}, 3'b100, {(2*FRAC_W){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ITER = 2'd2, S_DONE = 2'd3} state_t;
  state_t r_state, w_state_nxt;

  logic signed [W-1:0] r_re_start, r_im_start, r_re_scale, r_im_scale;
  logic [ITER_W-1:0]   r_max_iter, r_iter;
  logic [COORD_W-1:0]  r_x, r_y;
  logic signed [W-1:0] r_c_re, r_c_im, r_re, r_im;
  logic                r_escaped;
`ifdef JULIA_MODE_EN
  logic                r_julia;
  logic signed [W-1:0] r_jc_re, r_jc_im;
`endif

  // Clamp a wide signed sum into the W-bit signed range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
    logic signed [W-1:0] res;
    if (v[SW-1:W-1] == {(SW-W+1){v[SW-1]}}) res = v[W-1:0];
    else if (v[SW-1]) res = {1'b1, {(W-1){1'b0}}};
    else res = {1'b0, {(W-1){1'b1}}};
    return res;
  endfunction

  logic signed [PW-1:0] w_re_off, w_im_off;
  logic signed [SW-1:0] w_re_sum, w_im_sum;
  logic signed [W-1:0]  w_pix_re, w_pix_im, w_z0_re, w_z0_im, w_c0_re, w_c0_im;

  assign w_re_off = PW'(r_re_scale) * PW'($signed({1'b0, r_x}));
  assign w_im_off = PW'(r_im_scale) * PW'($signed({1'b0, r_y}));
  assign w_re_sum = SW'(w_re_off) + SW'(r_re_start);
  assign w_im_sum = SW'(w_im_off) + SW'(r_im_start);
  assign w_pix_re = sat_w(w_re_sum);
  assign w_pix_im = sat_w(w_im_sum);

`ifdef JULIA_MODE_EN
  assign w_z0_re = r_julia ? w_pix_re : {W{1'b0}};
  assign w_z0_im = r_julia ? w_pix_im : {W{1'b0}};
  assign w_c0_re = r_julia ? r_jc_re : w_pix_re;
  assign w_c0_im = r_julia ? r_jc_im : w_pix_im;
`else
  assign w_z0_re = {W{1'b0}};
  assign w_z0_im = {W{1'b0}};
  assign w_c0_re = w_pix_re;
  assign w_c0_im = w_pix_im;
`endif

  // Full-precision squares; the escape test uses the untruncated sum.
  logic signed [DW-1:0] w_re2, w_im2, w_p, w_mag, w_diff, w_re_sh, w_p_sh;
  logic signed [W-1:0]  w_re_nxt, w_im_nxt;
  logic                 w_esc, w_at_lim;

  assign w_re2    = DW'(r_re) * DW'(r_re);
  assign w_im2    = DW'(r_im) * DW'(r_im);
  assign w_p      = DW'(r_re) * DW'(r_im);
  assign w_mag    = w_re2 + w_im2;
  assign w_diff   = w_re2 - w_im2;
  assign w_re_sh  = w_diff >>> FRAC_W;
  assign w_p_sh   = w_p >>> (FRAC_W - 1);
  assign w_re_nxt = W'(w_re_sh) + r_c_re;
  assign w_im_nxt = W'(w_p_sh) + r_c_im;
  assign w_esc    = (w_mag > FOUR);
  assign w_at_lim = (r_iter == r_max_iter);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_SETUP;
        else          w_state_nxt = S_IDLE;
      end
      S_SETUP: w_state_nxt = S_ITER;
      S_ITER: begin
        if (w_esc || w_at_lim) w_state_nxt = S_DONE;
        else                   w_state_nxt = S_ITER;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, SETUP initialisation and the per-cycle z update.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_re_start <= {W{1'b0}};
      r_im_start <= {W{1'b0}};
      r_re_scale <= {W{1'b0}};
      r_im_scale <= {W{1'b0}};
      r_max_iter <= {ITER_W{1'b0}};
      r_iter     <= {ITER_W{1'b0}};
      r_x        <= {COORD_W{1'b0}};
      r_y        <= {COORD_W{1'b0}};
      r_c_re     <= {W{1'b0}};
      r_c_im     <= {W{1'b0}};
      r_re       <= {W{1'b0}};
      r_im       <= {W{1'b0}};
      r_escaped  <= 1'b0;
`ifdef JULIA_MODE_EN
      r_julia    <= 1'b0;
      r_jc_re    <= {W{1'b0}};
      r_jc_im    <= {W{1'b0}};
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x        <= in_x;
          r_y        <= in_y;
          r_re_start <= re_start;
          r_im_start <= im_start;
          r_re_scale <= re_scale;
          r_im_scale <= im_scale;
          r_max_iter <= max_iter;
`ifdef JULIA_MODE_EN
          r_julia    <= julia;
          r_jc_re    <= jc_re;
          r_jc_im    <= jc_im;
`endif
        end
        S_SETUP: begin
          r_c_re    <= w_c0_re;
          r_c_im    <= w_c0_im;
          r_re      <= w_z0_re;
          r_im      <= w_z0_im;
          r_iter    <= {ITER_W{1'b0}};
          r_escaped <= 1'b0;
        end
        S_ITER: begin
          if (w_esc || w_at_lim) begin
            r_escaped <= w_esc;
          end else begin
            r_re   <= w_re_nxt;
            r_im   <= w_im_nxt;
            r_iter <= r_iter + ITER_W'(1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_x       = r_x;
  assign out_y       = r_y;
  assign out_iter    = r_iter;
  assign out_escaped = r_escaped;

endmodule

// File: tb/tb_mandel_point_engine.sv
// Scoreboard bench for mandel_point_engine: a plain-arithmetic escape-time model predicts each result.
module tb_mandel_point_engine;
  localparam int INT_W = 4, FRAC_W = 28, COORD_W = 12, ITER_W = 16;
  localparam int W   = INT_W + FRAC_W;
  localparam int ONE = 1 << FRAC_W;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic in_valid, in_ready, out_valid, out_ready, out_escaped;
  logic [COORD_W-1:0] in_x, in_y, out_x, out_y;
  logic signed [W-1:0] re_start, im_start, re_scale, im_scale;
  logic [ITER_W-1:0] max_iter, out_iter;

  mandel_point_engine #(.INT_W(INT_W), .FRAC_W(FRAC_W), .COORD_W(COORD_W), .ITER_W(ITER_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .re_start(re_start), .im_start(im_start),
    .re_scale(re_scale), .im_scale(im_scale), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_iter(out_iter), .out_escaped(out_escaped)
  );

  typedef struct { int x; int y; int it; bit esc; int acc; } exp_t;
  exp_t exp_q[$];
  int nchk = 0, nerr = 0, cyc = 0;
  bit bp_en = 1'b0;
  bit prev_v = 1'b0;

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    longint hi, lo;
    hi = (longint'(1) << 31) - 1;
    lo = -(longint'(1) << 31);
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  function automatic logic signed [127:0] wrap32(input logic signed [127:0] v);
    logic signed [31:0] t;
    t = v[31:0];
    return 128'(t);
  endfunction

  // Escape-time reference: z values as Q4.28 integers, exact wide arithmetic, wrap to 32 bits.
  function automatic void model(input int rs, ims, rsc, isc, x, y, mi, output int it, output bit esc);
    logic signed [127:0] cr, ci, zr, zi, nr, ni, four;
    bit done;
    four = 128'sd1 <<< (2 * FRAC_W + 2);
    cr = 128'(sat32(longint'(rs) + longint'(rsc) * x));
    ci = 128'(sat32(longint'(ims) + longint'(isc) * y));
    zr = 0; zi = 0; it = 0; esc = 1'b0; done = 1'b0;
    while (!done) begin
      if (zr * zr + zi * zi > four) begin
        esc = 1'b1; done = 1'b1;
      end else if (it == mi) begin
        done = 1'b1;
      end else begin
        nr = ((zr * zr - zi * zi) >>> FRAC_W) + cr;
        ni = ((2 * zr * zi) >>> FRAC_W) + ci;
        zr = wrap32(nr);
        zi = wrap32(ni);
        it++;
      end
    end
  endfunction

  // Monitor: compares the presented result every cycle, checks latency on the rising edge, pops on handshake.
  initial forever begin
    @(negedge CLK);
    if (!RST_N) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_low_in_done", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          if (!prev_v) chk("latency", cyc - exp_q[0].acc, exp_q[0].it + 2);
          chk("out_x", out_x, exp_q[0].x);
          chk("out_y", out_y, exp_q[0].y);
          chk("out_iter", out_iter, exp_q[0].it);
          chk("out_escaped", out_escaped, exp_q[0].esc);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = out_valid;
    end
  end

  // Random backpressure when enabled.
  initial forever begin
    @(posedge CLK); #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int rs, ims, rsc, isc, x, y, mi);
    int it, n;
    bit esc;
    exp_t e;
    model(rs, ims, rsc, isc, x, y, mi, it, esc);
    in_x = COORD_W'(x); in_y = COORD_W'(y);
    re_start = rs; im_start = ims; re_scale = rsc; im_scale = isc;
    max_iter = ITER_W'(mi);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 5000) begin @(posedge CLK); #1; n++; end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge CLK); #1;
      e.x = x; e.y = y; e.it = it; e.esc = esc; e.acc = cyc;
      exp_q.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge CLK); #1; n++; end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_iter"}, out_iter, 0);
    chk({tag, "_out_escaped"}, out_escaped, 0);
    chk({tag, "_out_x"}, out_x, 0);
    chk({tag, "_out_y"}, out_y, 0);
  endtask

  initial begin
    int n;
    in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; re_start = '0; im_start = '0; re_scale = '0; im_scale = '0; max_iter = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset("por");
    RST_N = 1'b1;
    @(posedge CLK); #1;

    send(0, 0, 0, 0, 0, 0, 10);                      // origin: limit reached, latency 12
    send(2 * ONE, 0, 0, 0, 0, 0, 100);               // c=2: escapes after 2 updates
    send(-2 * ONE, 0, 0, 0, 0, 0, 50);               // c=-2: |z|^2 == 4 never escapes
    send(-2 * ONE, 0, 1 << 20, 0, 512, 0, 10);       // c_re = -2 + 512/256 = 0, tag 512
    send(5 * (ONE / 2), 0, 0, 0, 3, 4, 0);           // max_iter 0
    send(2 * ONE, 0, 0, 0, 1, 2, 2);                 // escape and limit together: escape wins
    send(15 * (ONE / 2), 0, ONE / 4, 0, 34, 0, 5);   // real sum 16.0 saturates high
    send(0, -15 * (ONE / 2), 0, -(ONE / 4), 0, 34, 5); // imag sum -16.0 saturates low
    send(-ONE / 2, ONE / 2, 1 << 10, -(1 << 10), 4095, 4095, 30);
    wait_idle();

    // Hold the result for 20 cycles while a competing request is offered.
    out_ready = 1'b0;
    send(2 * ONE, 0, 0, 0, 7, 9, 100);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge CLK); #1; n++; end
    chk("hold_reached_done", out_valid, 1);
    in_x = 12'd1; in_y = 12'd1; re_start = 0; max_iter = 16'd3; in_valid = 1'b1;
    repeat (20) begin
      @(posedge CLK); #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("after_hs_in_ready", in_ready, 1);
    chk("after_hs_out_valid", out_valid, 0);
    send(0, 0, 0, 0, 3, 4, 5);
    wait_idle();

    // Abort mid-iteration with reset.
    send(0, 0, 0, 0, 1, 1, 1000);
    repeat (10) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    check_reset("midrst");
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      chk("post_rst_no_valid", out_valid, 0);
    end
    send(2 * ONE, 0, 0, 0, 0, 0, 100);
    wait_idle();

    // Randomised region sweep with backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int rs, ims, rsc, isc;
      rs  = int'($urandom_range(0, 4 * ONE)) - 5 * (ONE / 2);
      ims = int'($urandom_range(0, 3 * ONE)) - 3 * (ONE / 2);
      rsc = int'($urandom_range(0, 1 << 19)) - (1 << 18);
      isc = int'($urandom_range(0, 1 << 19)) - (1 << 18);
      if (i % 8 == 7) rsc = int'($urandom());
      send(rs, ims, rsc, isc, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 40)));
    end
    wait_idle();
    bp_en = 1'b0;
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/mandel_point_engine.md
Name: mandel_point_engine

Overview:
- Next-generation escape-time engine for the Mandelbrot renderer: takes a pixel coordinate plus a view window and iterates z <- z^2 + c until escape or an iteration limit.
- Returns the iteration count with the pixel tag through valid/ready handshakes.
- Generalised fixed-point width, runtime iteration limit and input/output flow control.
- Sits between the pixel scheduler and the colour-map/framebuffer writer; several instances run in parallel.

Parameters:
- INT_W, 4, integer bits of signed fixed point, sign bit included.
- FRAC_W, 28, fractional bits; total word W = INT_W+FRAC_W.
- COORD_W, 12, width of pixel x/y coordinates.
- ITER_W, 16, width of iteration count and limit.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  engine can accept a request
- in_x  in  COORD_W  pixel column (unsigned)
- in_y  in  COORD_W  pixel row (unsigned)
- re_start  in  W  signed real coordinate of column 0
- im_start  in  W  signed imaginary coordinate of row 0
- re_scale  in  W  signed real step per column
- im_scale  in  W  signed imaginary step per row
- max_iter  in  ITER_W  iteration limit
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_x  out  COORD_W  tag: latched in_x
- out_y  out  COORD_W  tag: latched in_y
- out_iter  out  ITER_W  completed z-updates
- out_escaped  out  1  1 = |z|^2 exceeded 4; 0 = limit reached

Behaviour:
- Reset (async, RST_N=0): state=IDLE, in_ready=1, out_valid=0, out_iter=0, out_escaped=0, out_x=0, out_y=0, internal z=0. Reset mid-operation aborts the pixel; no result is produced.
- States: IDLE, SETUP, ITER, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid&in_ready, latch x, y, all window inputs and max_iter, then go to SETUP. Inputs are ignored in every other state.
- SETUP (1 cycle):
  - c_re = re_start + re_scale*x; c_im = im_start + im_scale*y.
  - Products are computed at full width, with x and y zero-extended as integers.
  - Sums saturate to the W-bit signed range.
  - z=0, iter=0, then go to ITER.
- ITER, once per cycle:
  - Squares: re2 = re*re, im2 = im*im, p = re*im, each full 2W product.
  - Escape test on full-precision re2+im2 > 4.0 (strictly greater).
  - If escaped: DONE, out_escaped=1.
  - Else if iter==max_iter: DONE, out_escaped=0.
  - Else: re <= (re2-im2)>>>FRAC_W + c_re; im <= (p>>>(FRAC_W-1)) + c_im, i.e. 2·re·im. Shifts are arithmetic (truncate toward -inf). iter <= iter+1.
  - Escape and limit in the same cycle: escape wins.
  - max_iter=0: DONE after first ITER cycle, out_iter=0, out_escaped=1 only if |c| test fires (z=0 never escapes, so 0).
- DONE:
  - out_valid=1; out_x, out_y, out_iter, out_escaped are stable until out_valid&out_ready.
  - On the handshake, go to IDLE. in_ready rises the following cycle; there is no same-cycle turnaround.
- Latency: with k updates, out_valid rises k+2 cycles after the accept edge.
- iter never wraps; it is bounded by max_iter.

Optional Feature:
- JULIA_MODE_EN defined: adds input julia (1) and inputs jc_re, jc_im (W).
  - When julia=1 at accept: z0 = the SETUP-computed pixel point, c = latched (jc_re, jc_im).
  - When julia=0: Mandelbrot behaviour, as above.
- Undefined: ports are absent; the block is Mandelbrot-only, as above.

Test Plan:
- re_start=im_start=0, x=y=0, max_iter=10 -> out_iter=10, out_escaped=0, out_valid 12 cycles after accept.
- c=(2.0,0) via re_start=2.0, scale=0, max_iter=100 -> z:0,2,6 -> out_iter=2, out_escaped=1.
- c=(-2.0,0), max_iter=50 -> z sits at 2.0, |z|^2=4 not >4 -> out_iter=50, out_escaped=0 (boundary).
- re_start=-2.0, re_scale=2^-8, x=512, y=0, im_start=0 -> c_re=0 -> same as first case; out_x=512 tag held.
- Hold out_ready=0 for 20 cycles in DONE -> out_valid and outputs stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE, then the next request is accepted.
- Drop RST_N mid-ITER, then release and issue c=(2.0,0) -> no stale out_valid; fresh result out_iter=2.
